// File: rtl/arcade_input_mapper.sv
// Merges PS/2 key events (via a loadable keymap) and joystick words into registered active-low button vectors.
// Optional autofire on button AUTOFIRE_BIT is built only when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_mapper #(
   parameter int          NUM_PLAYERS  = 2,
   parameter int          NUM_BUTTONS  = 12,
   parameter int          COIN_BIT     = 8,
   parameter logic [15:0] COIN_MIN     = 16'd50000,
   parameter int          AUTOFIRE_BIT = 4,
   parameter logic [19:0] AUTOFIRE_DIV = 20'd400000,
   localparam int         NUM_ENTRIES  = NUM_PLAYERS * NUM_BUTTONS,
   localparam int         ADDR_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic                       clk_sys,
   input  logic                       reset_n,
   input  logic [10:0]                ps2_key,
   input  logic [NUM_PLAYERS*16-1:0]  joy_in,
   input  logic                       map_wr,
   input  logic [ADDR_W-1:0]          map_addr,
   input  logic [8:0]                 map_data,
   input  logic                       autofire_on,
   output logic [NUM_ENTRIES-1:0]     btn_n,
   output logic                       busy,
   output logic                       ev_overflow
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRIES - 1);
   // The rising-edge cycle itself counts as the first stretched cycle.
   localparam logic [15:0] COIN_LOAD = (COIN_MIN == 16'd0) ? 16'd0 : COIN_MIN - 16'd1;

   function automatic logic [8:0] default_entry(input int i);
      case (i)
         0:       return 9'h174;
         1:       return 9'h16B;
         2:       return 9'h172;
         3:       return 9'h175;
         4:       return 9'h014;
         5:       return 9'h029;
         default: return 9'h000;
      endcase
   endfunction

   state_t                 state, state_d;
   logic [ADDR_W-1:0]      idx, idx_d;
   logic                   lat_pressed, lat_pressed_d;
   logic [8:0]             lat_code, lat_code_d;
   logic                   pend_valid, pend_valid_d;
   logic                   pend_pressed, pend_pressed_d;
   logic [8:0]             pend_code, pend_code_d;
   logic                   overflow_d;
   logic                   tog_q, primed;
   logic                   key_event;
   logic                   addr_ok;
   logic                   hit;
   logic [8:0]             keymap [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] key_state;
   logic [NUM_ENTRIES-1:0] raw, merged;
   logic [15:0]            coin_cnt [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] coin_prev;
   logic                   joy_unused;

   assign key_event  = primed && (ps2_key[10] != tog_q);
   assign addr_ok    = ({1'b0, map_addr} < (ADDR_W+1)'(NUM_ENTRIES));
   assign hit        = (keymap[idx] == lat_code) && (keymap[idx] != 9'h000);
   assign busy       = (state == SCAN);
   assign joy_unused = ^joy_in;

   // The toggle register is loaded without compare on the first cycle out of reset.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         tog_q  <= 1'b0;
         primed <= 1'b0;
      end else begin
         tog_q  <= ps2_key[10];
         primed <= 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) keymap[i] <= default_entry(i);
      end else if (map_wr && addr_ok) begin
         keymap[map_addr] <= map_data;
      end
   end

   // A keymap write clears that entry's held state, overriding a same-cycle match.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         key_state <= '0;
      end else begin
         if (state == SCAN && hit) key_state[idx] <= lat_pressed;
         if (map_wr && addr_ok)    key_state[map_addr] <= 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         idx          <= '0;
         lat_pressed  <= 1'b0;
         lat_code     <= '0;
         pend_valid   <= 1'b0;
         pend_pressed <= 1'b0;
         pend_code    <= '0;
         ev_overflow  <= 1'b0;
      end else begin
         state        <= state_d;
         idx          <= idx_d;
         lat_pressed  <= lat_pressed_d;
         lat_code     <= lat_code_d;
         pend_valid   <= pend_valid_d;
         pend_pressed <= pend_pressed_d;
         pend_code    <= pend_code_d;
         ev_overflow  <= overflow_d;
      end
   end

   // On the final entry the pending slot is consumed, so a same-cycle event may refill it.
   always_comb begin
      state_d        = state;
      idx_d          = idx;
      lat_pressed_d  = lat_pressed;
      lat_code_d     = lat_code;
      pend_valid_d   = pend_valid;
      pend_pressed_d = pend_pressed;
      pend_code_d    = pend_code;
      overflow_d     = ev_overflow;
      case (state)
         IDLE: begin
            if (key_event) begin
               state_d       = SCAN;
               idx_d         = '0;
               lat_pressed_d = ps2_key[9];
               lat_code_d    = ps2_key[8:0];
            end
         end
         SCAN: begin
            if (idx == LAST_IDX) begin
               idx_d = '0;
               if (pend_valid) begin
                  lat_pressed_d = pend_pressed;
                  lat_code_d    = pend_code;
                  pend_valid_d  = key_event;
                  if (key_event) begin
                     pend_pressed_d = ps2_key[9];
                     pend_code_d    = ps2_key[8:0];
                  end
               end else if (key_event) begin
                  lat_pressed_d = ps2_key[9];
                  lat_code_d    = ps2_key[8:0];
               end else begin
                  state_d = IDLE;
               end
            end else begin
               idx_d = idx + 1'b1;
               if (key_event) begin
                  if (!pend_valid) begin
                     pend_valid_d   = 1'b1;
                     pend_pressed_d = ps2_key[9];
                     pend_code_d    = ps2_key[8:0];
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      raw = key_state;
      for (int p = 0; p < NUM_PLAYERS; p++)
         for (int b = 0; b < NUM_BUTTONS; b++)
            if (b < 16) raw[p*NUM_BUTTONS+b] = key_state[p*NUM_BUTTONS+b] | joy_in[p*16+b];
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         coin_prev <= '0;
         for (int p = 0; p < NUM_PLAYERS; p++) coin_cnt[p] <= '0;
      end else begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            coin_prev[p] <= raw[p*NUM_BUTTONS+COIN_BIT];
            if (raw[p*NUM_BUTTONS+COIN_BIT] && !coin_prev[p])
               coin_cnt[p] <= COIN_LOAD;
            else if (coin_cnt[p] != 16'd0)
               coin_cnt[p] <= coin_cnt[p] - 16'd1;
         end
      end
   end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
   logic [19:0] af_cnt;
   logic        af_phase;

   // Phase starts low so the first autofire half-period reads as released.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         af_cnt   <= '0;
         af_phase <= 1'b0;
      end else if (af_cnt >= AUTOFIRE_DIV - 20'd1) begin
         af_cnt   <= '0;
         af_phase <= ~af_phase;
      end else begin
         af_cnt <= af_cnt + 20'd1;
      end
   end
`else
   logic autofire_unused;
   assign autofire_unused = autofire_on;
`endif

   always_comb begin
      merged = raw;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         merged[p*NUM_BUTTONS+COIN_BIT] = raw[p*NUM_BUTTONS+COIN_BIT] | (coin_cnt[p] != 16'd0);
`ifdef ARCADE_INPUT_AUTOFIRE_EN
         if (autofire_on && raw[p*NUM_BUTTONS+AUTOFIRE_BIT])
            merged[p*NUM_BUTTONS+AUTOFIRE_BIT] = merged[p*NUM_BUTTONS+AUTOFIRE_BIT] & af_phase;
`endif
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) btn_n <= '1;
      else          btn_n <= ~merged;
   end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: joystick vector table plus hand-written
// key-scan, keymap-write, overflow, coin-stretch and autofire sequences.
module tb_arcade_input_mapper;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [10:0] ps2_key;
   logic [31:0] joy_in;
   logic        map_wr;
   logic [4:0]  map_addr;
   logic [8:0]  map_data;
   logic        autofire_on;
   logic [23:0] btn_n;
   logic        busy;
   logic        ev_overflow;

   int   vec_count  = 0;
   int   miss_count = 0;
   logic tog        = 1'b0;

   typedef struct {
      logic [31:0] joy;
      logic [23:0] exp_btn;
   } vec_t;

   vec_t vecs[7];

   arcade_input_mapper #(
      .NUM_PLAYERS (2),
      .NUM_BUTTONS (12),
      .COIN_BIT    (8),
      .COIN_MIN    (16'd100),
      .AUTOFIRE_BIT(4),
      .AUTOFIRE_DIV(20'd10)
   ) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .ps2_key    (ps2_key),
      .joy_in     (joy_in),
      .map_wr     (map_wr),
      .map_addr   (map_addr),
      .map_data   (map_data),
      .autofire_on(autofire_on),
      .btn_n      (btn_n),
      .busy       (busy),
      .ev_overflow(ev_overflow)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   // One PS/2 event: flip the toggle bit, return at the following negedge.
   task automatic applyStimulus(input logic pressed, input logic [8:0] code);
      tog     = ~tog;
      ps2_key = {tog, pressed, code};
      @(negedge clk_sys);
   endtask

   task automatic pressKey(input logic pressed, input logic [8:0] code);
      applyStimulus(pressed, code);
      waitCycles(26);
   endtask

   task automatic mapWrite(input logic [4:0] addr, input logic [8:0] data);
      map_wr   = 1'b1;
      map_addr = addr;
      map_data = data;
      @(negedge clk_sys);
      map_wr   = 1'b0;
   endtask

   initial begin
      int busy_cycles;
      int low_cycles;

      vecs[0] = '{32'h0000_0000, 24'hFFFFFF};
      vecs[1] = '{32'h0000_0001, 24'hFFFFFE};
      vecs[2] = '{32'h0008_0000, 24'hFF7FFF};
      vecs[3] = '{32'h0800_000F, 24'h7FFFF0};
      vecs[4] = '{32'h0000_F000, 24'hFFFFFF};
      vecs[5] = '{32'h0030_0000, 24'hFCFFFF};
      vecs[6] = '{32'hF000_0000, 24'hFFFFFF};

      reset_n     = 1'b0;
      ps2_key     = '0;
      joy_in      = '0;
      map_wr      = 1'b0;
      map_addr    = '0;
      map_data    = '0;
      autofire_on = 1'b0;
      waitCycles(3);
      checkOutput("reset_btn_n", 32'(btn_n), 32'hFFFFFF);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      checkOutput("reset_overflow", 32'(ev_overflow), 32'h0);
      reset_n = 1'b1;
      waitCycles(3);

      for (int i = 0; i < 7; i++) begin
         joy_in = vecs[i].joy;
         @(negedge clk_sys);
         checkOutput($sformatf("joy_vec%0d", i), 32'(btn_n), 32'(vecs[i].exp_btn));
      end
      joy_in = '0;
      waitCycles(2);

      applyStimulus(1'b1, 9'h014);
      busy_cycles = 0;
      for (int k = 1; k <= 30; k++) begin
         if (busy) busy_cycles++;
         if (k == 6) checkOutput("key4_before_compare", 32'(btn_n[4]), 32'h1);
         if (k == 7) checkOutput("key4_after_compare", 32'(btn_n[4]), 32'h0);
         @(negedge clk_sys);
      end
      checkOutput("busy_length", 32'(busy_cycles), 32'd24);
      checkOutput("key4_held", 32'(btn_n), 32'hFFFFEF);
      pressKey(1'b0, 9'h014);
      checkOutput("key4_released", 32'(btn_n), 32'hFFFFFF);

      pressKey(1'b1, 9'h174);
      checkOutput("ext_right_press", 32'(btn_n), 32'hFFFFFE);
      pressKey(1'b1, 9'h074);
      checkOutput("nonext_no_match", 32'(btn_n), 32'hFFFFFE);
      pressKey(1'b0, 9'h174);
      checkOutput("ext_right_release", 32'(btn_n), 32'hFFFFFF);

      mapWrite(5'd13, 9'h01C);
      pressKey(1'b1, 9'h01C);
      checkOutput("remap_press", 32'(btn_n), 32'hFFDFFF);
      mapWrite(5'd13, 9'h000);
      waitCycles(1);
      checkOutput("remap_clear_held", 32'(btn_n[13]), 32'h1);
      pressKey(1'b0, 9'h01C);
      checkOutput("remap_after_release", 32'(btn_n), 32'hFFFFFF);

      mapWrite(5'd16, 9'h014);
      mapWrite(5'd30, 9'h014);
      pressKey(1'b1, 9'h014);
      checkOutput("multi_map_press", 32'(btn_n), 32'hFEFFEF);
      pressKey(1'b0, 9'h014);
      checkOutput("multi_map_release", 32'(btn_n), 32'hFFFFFF);

      applyStimulus(1'b1, 9'h174);
      applyStimulus(1'b1, 9'h16B);
      applyStimulus(1'b1, 9'h172);
      checkOutput("overflow_set", 32'(ev_overflow), 32'h1);
      waitCycles(7);
      checkOutput("first_event_first", 32'(btn_n[2:0]), 32'b110);
      waitCycles(50);
      checkOutput("second_event_applied", 32'(btn_n[2:0]), 32'b100);
      checkOutput("overflow_sticky", 32'(ev_overflow), 32'h1);
      checkOutput("idle_after_two", 32'(busy), 32'h0);

      reset_n = 1'b0;
      tog     = ~tog;
      ps2_key = {tog, 1'b1, 9'h014};
      #1;
      checkOutput("reset2_overflow", 32'(ev_overflow), 32'h0);
      checkOutput("reset2_btn_n", 32'(btn_n), 32'hFFFFFF);
      @(negedge clk_sys);
      reset_n = 1'b1;
      waitCycles(3);
      checkOutput("no_event_first_cycle", 32'(busy), 32'h0);
      pressKey(1'b1, 9'h014);
      checkOutput("keymap_defaults_back", 32'(btn_n), 32'hFFFFEF);
      pressKey(1'b0, 9'h014);

      joy_in[8]  = 1'b1;
      low_cycles = 0;
      for (int k = 1; k <= 150; k++) begin
         @(negedge clk_sys);
         if (!btn_n[8]) low_cycles++;
         if (k == 1) joy_in[8] = 1'b0;
      end
      checkOutput("coin_stretch_len", 32'(low_cycles), 32'd100);

      joy_in[8]  = 1'b1;
      low_cycles = 0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk_sys);
         if (!btn_n[8]) low_cycles++;
         if (k == 1)  joy_in[8] = 1'b0;
         if (k == 50) joy_in[8] = 1'b1;
         if (k == 51) joy_in[8] = 1'b0;
      end
      checkOutput("coin_repress_len", 32'(low_cycles), 32'd150);

      autofire_on = 1'b1;
      joy_in[4]   = 1'b1;
      low_cycles  = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk_sys);
         if (!btn_n[4]) low_cycles++;
      end
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      checkOutput("autofire_on_duty", 32'(low_cycles), 32'd20);
`else
      checkOutput("autofire_on_duty", 32'(low_cycles), 32'd40);
`endif
      autofire_on = 1'b0;
      @(negedge clk_sys);
      low_cycles = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk_sys);
         if (!btn_n[4]) low_cycles++;
      end
      checkOutput("autofire_off_held", 32'(low_cycles), 32'd40);
      joy_in = '0;
      waitCycles(2);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
